// File: rtl/gaussian_blur_pkg.sv
// rtl/gaussian_blur_pkg.sv - image geometry and 3x3 Gaussian kernel weights
// Purpose: shared constants for the blur stage (default frame size, kernel
//          weights) and a helper that scales one pixel by a kernel weight.
// Ports:   none (package).
package gaussian_blur_pkg;

  localparam int WIDTH  = 720;
  localparam int HEIGHT = 540;

  // Kernel [1 2 1; 2 4 2; 1 2 1], normalised by 16 at the output.
  localparam logic [2:0] K_CORNER = 3'd1;
  localparam logic [2:0] K_EDGE   = 3'd2;
  localparam logic [2:0] K_CENTRE = 3'd4;

  // 12 bits hold the worst-case sum 16*255 = 4080.
  function automatic logic [11:0] weigh(input logic [7:0] pix, input logic [2:0] k);
    return 12'(pix) * 12'(k);
  endfunction

endpackage

// File: rtl/gaussian_blur.sv
// rtl/gaussian_blur.sv - 3x3 Gaussian blur between two pixel FIFOs
// Purpose: pops grayscale pixels in raster order, pushes one blurred pixel per
//          input pixel; frame-border outputs are forced to 0.
// Ports:   clock, reset (sync, active-low)
//          in_rd_en / in_empty / in_dout    - upstream FIFO pop side
//          out_wr_en / out_full / out_din   - downstream FIFO push side
module gaussian_blur #(
  parameter int WIDTH  = gaussian_blur_pkg::WIDTH,
  parameter int HEIGHT = gaussian_blur_pkg::HEIGHT
) (
  input  logic       clock,
  input  logic       reset,
  output logic       in_rd_en,
  input  logic       in_empty,
  input  logic [7:0] in_dout,
  output logic       out_wr_en,
  input  logic       out_full,
  output logic [7:0] out_din
);
  import gaussian_blur_pkg::*;

  localparam int SR_LEN = 2 * WIDTH + 3;
  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int CW     = $clog2(NPIX + 1);
  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_WRITE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [7:0]      sr [SR_LEN];
  logic [CW-1:0]   rd_cnt;
  logic [XW-1:0]   ox;
  logic [YW-1:0]   oy;
  logic [11:0]     sum;
  logic            border;
  logic            last_out;
  logic            filling;

  // sr[0] is the newest pixel; the centre lags it by WIDTH+1 pixels.
  assign sum = weigh(sr[0], K_CORNER)          + weigh(sr[1], K_EDGE)
             + weigh(sr[2], K_CORNER)          + weigh(sr[WIDTH], K_EDGE)
             + weigh(sr[WIDTH+1], K_CENTRE)    + weigh(sr[WIDTH+2], K_EDGE)
             + weigh(sr[2*WIDTH], K_CORNER)    + weigh(sr[2*WIDTH+1], K_EDGE)
             + weigh(sr[2*WIDTH+2], K_CORNER);

  assign border = (ox == '0) || (ox == XW'(WIDTH - 1)) ||
                  (oy == '0) || (oy == YW'(HEIGHT - 1));
  assign last_out = (ox == XW'(WIDTH - 1)) && (oy == YW'(HEIGHT - 1));
  // rd_cnt is the index of the pop about to happen; the first WIDTH+1 only prime the window.
  assign filling = rd_cnt < CW'(WIDTH + 1);

  always_comb begin
    next_state = state;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    out_din    = 8'd0;
    if (reset) begin
      case (state)
        S_READ: begin
          if (!in_empty) begin
            in_rd_en = 1'b1;
            if (!filling) next_state = S_WRITE;
          end
        end
        S_WRITE: begin
          out_din = border ? 8'd0 : sum[11:4];
          if (!out_full) begin
            out_wr_en  = 1'b1;
            next_state = (rd_cnt == CW'(NPIX)) ? S_DRAIN : S_READ;
          end
        end
        S_DRAIN: begin
          // Everything left after the last pop is bottom row or right column.
          if (!out_full) begin
            out_wr_en = 1'b1;
            if (last_out) next_state = S_READ;
          end
        end
        default: next_state = S_READ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= S_READ;
      rd_cnt <= '0;
      ox     <= '0;
      oy     <= '0;
      for (int i = 0; i < SR_LEN; i++) sr[i] <= 8'd0;
    end else begin
      state <= next_state;
      if (in_rd_en) begin
        for (int i = SR_LEN - 1; i > 0; i--) sr[i] <= sr[i-1];
        sr[0]  <= in_dout;
        rd_cnt <= rd_cnt + CW'(1);
      end
      if (out_wr_en) begin
        if (last_out) begin
          ox     <= '0;
          oy     <= '0;
          rd_cnt <= '0;
        end else if (ox == XW'(WIDTH - 1)) begin
          ox <= '0;
          oy <= oy + YW'(1);
        end else begin
          ox <= ox + XW'(1);
        end
      end
    end
  end

endmodule
